// File: rtl/lcd_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lcd_controller                                             |
// | Description : Drives an HD44780-compatible 16x2 character LCD. Performs  |
// |               the power-up wait and init command sequence, then rewrites |
// |               both display lines from a 32-byte snapshot of `text` on    |
// |               each `update` request. One request can be queued while     |
// |               busy; further strobes collapse into it.                    |
// | Ports       : clk       - master clock, rising edge                      |
// |               reset     - synchronous, active-low                        |
// |               text      - 32 chars, byte k = text[8k+7:8k]               |
// |                           (k=0..15 line 1, k=16..31 line 2)              |
// |               update    - one-cycle refresh request strobe               |
// |               busy      - high while initialising or refreshing          |
// |               LCD_DATA  - LCD data bus                                   |
// |               LCD_RS    - 0 = command, 1 = data                          |
// |               LCD_RW    - always 0 (write only)                          |
// |               LCD_EN    - LCD enable strobe                              |
// |               LCD_ON    - panel power, 1 once out of reset               |
// | Options     : `define LCD_CHAR_FILTER_EN replaces non-printable data     |
// |               bytes (outside 0x20..0x7E) with 0x20 at snapshot time.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lcd_controller #(
    parameter int CLK_HZ            = 50000000,
    parameter int POWERUP_CYCLES    = 750000,
    parameter int EN_PULSE_CYCLES   = 16,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] text,
    input  logic         update,
    output logic         busy,
    output logic [7:0]   LCD_DATA,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic         LCD_EN,
    output logic         LCD_ON
);

    // All timing parameters are cycle counts loaded as (N-1) and counted down
    // to zero, so each must be at least 1.
    if (CLK_HZ < 1 || POWERUP_CYCLES < 1 || EN_PULSE_CYCLES < 1 ||
        CMD_WAIT_CYCLES < 1 || CLEAR_WAIT_CYCLES < 1) begin : g_param_check
        $error("lcd_controller: timing parameters must be >= 1");
    end

    localparam int c_max_a   = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int c_max_b   = (CMD_WAIT_CYCLES > EN_PULSE_CYCLES) ? CMD_WAIT_CYCLES : EN_PULSE_CYCLES;
    localparam int c_cnt_max = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_pwrup_ld = c_cnt_w'(POWERUP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_en_ld    = c_cnt_w'(EN_PULSE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cmd_ld   = c_cnt_w'(CMD_WAIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_clr_ld   = c_cnt_w'(CLEAR_WAIT_CYCLES - 1);

    // Top-level sequence states
    localparam logic [2:0] c_st_pwrup = 3'd0;
    localparam logic [2:0] c_st_init  = 3'd1;
    localparam logic [2:0] c_st_idle  = 3'd2;
    localparam logic [2:0] c_st_addr1 = 3'd3;
    localparam logic [2:0] c_st_line1 = 3'd4;
    localparam logic [2:0] c_st_addr2 = 3'd5;
    localparam logic [2:0] c_st_line2 = 3'd6;

    // Byte-write phases, shared by every write state
    localparam logic [1:0] c_ph_setup = 2'd0;
    localparam logic [1:0] c_ph_pulse = 2'd1;
    localparam logic [1:0] c_ph_hold  = 2'd2;
    localparam logic [1:0] c_ph_wait  = 2'd3;

    logic [2:0]         r_state, w_state_nx;
    logic [1:0]         r_phase, w_phase_nx;
    logic [c_cnt_w-1:0] r_cnt,   w_cnt_nx;
    logic [4:0]         r_idx,   w_idx_nx;      // init step or character index
    logic               r_pend,  w_pend_nx;
    logic [255:0]       r_buf;
    logic               r_busy;
    logic               r_on;
    logic               w_snap;
    logic               w_last;
    logic               w_writing;
    logic [7:0]         w_byte;
    logic               w_rs;
    logic [255:0]       w_snap_text;

`ifdef LCD_CHAR_FILTER_EN
    for (genvar k = 0; k < 32; k++) begin : g_filter
        assign w_snap_text[8*k +: 8] =
            (text[8*k +: 8] < 8'h20 || text[8*k +: 8] > 8'h7E) ? 8'h20 : text[8*k +: 8];
    end
`else
    assign w_snap_text = text;
`endif

    assign w_writing = (r_state == c_st_init)  || (r_state == c_st_addr1) ||
                       (r_state == c_st_line1) || (r_state == c_st_addr2) ||
                       (r_state == c_st_line2);

    // Byte and RS presented on the bus, held for the whole write of one byte
    always_comb begin
        w_byte = 8'h00;
        w_rs   = 1'b0;
        case (r_state)
            c_st_init: begin
                case (r_idx)
                    5'd0, 5'd1, 5'd2: w_byte = 8'h38;
                    5'd3:             w_byte = 8'h0C;
                    5'd4:             w_byte = 8'h01;
                    default:          w_byte = 8'h06;
                endcase
            end
            c_st_addr1: w_byte = 8'h80;
            c_st_addr2: w_byte = 8'hC0;
            c_st_line1, c_st_line2: begin
                w_byte = r_buf[{r_idx, 3'b000} +: 8];
                w_rs   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_pend_nx  = r_pend | update;
        w_snap     = 1'b0;
        w_last     = 1'b0;

        case (r_state)
            c_st_pwrup: begin
                if (r_cnt == '0) begin
                    w_state_nx = c_st_init;
                    w_phase_nx = c_ph_setup;
                    w_idx_nx   = 5'd0;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end

            c_st_idle: begin
                w_pend_nx = 1'b0;
                if (update) begin
                    w_state_nx = c_st_addr1;
                    w_phase_nx = c_ph_setup;
                    w_idx_nx   = 5'd0;
                    w_snap     = 1'b1;
                end
            end

            c_st_init, c_st_addr1, c_st_line1, c_st_addr2, c_st_line2: begin
                case (r_phase)
                    c_ph_setup: begin
                        w_phase_nx = c_ph_pulse;
                        w_cnt_nx   = c_en_ld;
                    end
                    c_ph_pulse: begin
                        if (r_cnt == '0) w_phase_nx = c_ph_hold;
                        else             w_cnt_nx   = r_cnt - 1'b1;
                    end
                    c_ph_hold: begin
                        w_phase_nx = c_ph_wait;
                        // Only the clear command needs the long settle time
                        w_cnt_nx   = (!w_rs && w_byte == 8'h01) ? c_clr_ld : c_cmd_ld;
                    end
                    default: begin
                        if (r_cnt != '0) begin
                            w_cnt_nx = r_cnt - 1'b1;
                        end else begin
                            w_phase_nx = c_ph_setup;
                            case (r_state)
                                c_st_init: begin
                                    if (r_idx == 5'd5) w_last   = 1'b1;
                                    else               w_idx_nx = r_idx + 1'b1;
                                end
                                c_st_addr1: begin
                                    w_state_nx = c_st_line1;
                                    w_idx_nx   = 5'd0;
                                end
                                c_st_line1: begin
                                    if (r_idx == 5'd15) begin
                                        w_state_nx = c_st_addr2;
                                        w_idx_nx   = 5'd16;
                                    end else begin
                                        w_idx_nx = r_idx + 1'b1;
                                    end
                                end
                                c_st_addr2: begin
                                    w_state_nx = c_st_line2;
                                    w_idx_nx   = 5'd16;
                                end
                                default: begin
                                    if (r_idx == 5'd31) w_last   = 1'b1;
                                    else                w_idx_nx = r_idx + 1'b1;
                                end
                            endcase
                        end
                    end
                endcase

                // End of init or refresh: chain straight into a queued request
                // (including one strobed this very cycle) without visiting IDLE.
                if (w_last) begin
                    w_pend_nx = 1'b0;
                    w_idx_nx  = 5'd0;
                    if (r_pend || update) begin
                        w_state_nx = c_st_addr1;
                        w_snap     = 1'b1;
                    end else begin
                        w_state_nx = c_st_idle;
                    end
                end
            end

            default: begin
                w_state_nx = c_st_pwrup;
                w_phase_nx = c_ph_setup;
                w_cnt_nx   = c_pwrup_ld;
                w_idx_nx   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_pwrup;
            r_phase <= c_ph_setup;
            r_cnt   <= c_pwrup_ld;
            r_idx   <= 5'd0;
            r_pend  <= 1'b0;
            r_buf   <= {32{8'h20}};
            r_busy  <= 1'b1;
            r_on    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_phase <= w_phase_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_pend  <= w_pend_nx;
            r_busy  <= (w_state_nx != c_st_idle);
            r_on    <= 1'b1;
            if (w_snap) r_buf <= w_snap_text;
        end
    end

    assign busy     = r_busy;
    assign LCD_DATA = w_byte;
    assign LCD_RS   = w_rs;
    assign LCD_RW   = 1'b0;
    assign LCD_EN   = w_writing && (r_phase == c_ph_pulse);
    assign LCD_ON   = r_on;

endmodule
`default_nettype wire

// File: tb/tb_lcd_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lcd_controller                                          |
// | Description : Self-checking bench for lcd_controller. Captures every     |
// |               LCD_EN falling edge (data, RS, high time, preceding low    |
// |               time) and compares against hand-derived sequences.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_lcd_controller;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [255:0] text = {32{8'h20}};
    logic         update = 1'b0;
    logic         busy;
    logic [7:0]   LCD_DATA;
    logic         LCD_RS, LCD_RW, LCD_EN, LCD_ON;

    lcd_controller #(
        .CLK_HZ(50000000), .POWERUP_CYCLES(20), .EN_PULSE_CYCLES(2),
        .CMD_WAIT_CYCLES(4), .CLEAR_WAIT_CYCLES(10)
    ) dut (
        .clk(clk), .reset(reset), .text(text), .update(update), .busy(busy),
        .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .LCD_ON(LCD_ON)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor, sampled on the falling clock edge
    logic [7:0] cap_data[$];
    logic       cap_rs[$];
    int         cap_hi[$];
    int         gap_q[$];
    int         lowcnt = 0, hicnt = 0, busy_low = 0;
    logic       prev_en = 1'b0;

    always @(negedge clk) begin
        if (LCD_EN) begin
            if (!prev_en) begin
                gap_q.push_back(lowcnt);
                hicnt = 0;
            end
            hicnt++;
        end else begin
            if (prev_en) begin
                cap_data.push_back(LCD_DATA);
                cap_rs.push_back(LCD_RS);
                cap_hi.push_back(hicnt);
                lowcnt = 0;
            end
            lowcnt++;
        end
        prev_en = LCD_EN;
        if (!busy) busy_low++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_data.delete(); cap_rs.delete(); cap_hi.delete(); gap_q.delete();
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy && n < bound) begin tick(); n++; end
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_caps(input string tag, input int cnt, input int bound);
        int n = 0;
        while (cap_data.size() < cnt && n < bound) begin tick(); n++; end
        check(tag, (cap_data.size() >= cnt), 1'b1);
    endtask

    function automatic logic [255:0] mk_text(input string s);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = (k < s.len()) ? s[k] : 8'h20;
        return r;
    endfunction

    function automatic logic [7:0] flt(input logic [7:0] b);
`ifdef LCD_CHAR_FILTER_EN
        return (b < 8'h20 || b > 8'h7E) ? 8'h20 : b;
`else
        return b;
`endif
    endfunction

    task automatic check_init();
        logic [7:0] seq [6];
        seq = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        check("init_count", cap_data.size(), 6);
        if (cap_data.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("init_data%0d", i), cap_data[i], seq[i]);
                check($sformatf("init_rs%0d", i), cap_rs[i], 1'b0);
                check($sformatf("init_en_hi%0d", i), cap_hi[i], 2);
            end
            check("init_gap_after_clear", (gap_q.size() >= 6 && gap_q[5] >= 10), 1'b1);
        end
    endtask

    // Expected write i (0..33) of a refresh from snapshot t
    task automatic check_refresh(input string tag, input logic [255:0] t, input int base);
        logic [7:0] ed;
        logic       er;
        check({tag, "_count"}, (cap_data.size() >= base + 34), 1'b1);
        if (cap_data.size() >= base + 34) begin
            for (int i = 0; i < 34; i++) begin
                if (i == 0)       begin ed = 8'h80; er = 1'b0; end
                else if (i <= 16) begin ed = flt(t[8*(i-1) +: 8]); er = 1'b1; end
                else if (i == 17) begin ed = 8'hC0; er = 1'b0; end
                else              begin ed = flt(t[8*(i-2) +: 8]); er = 1'b1; end
                check($sformatf("%s_data%0d", tag, i), cap_data[base+i], ed);
                check($sformatf("%s_rs%0d", tag, i), cap_rs[base+i], er);
                check($sformatf("%s_en_hi%0d", tag, i), cap_hi[base+i], 2);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] t1, t2, t3, t4;

        // ---------------- reset state ----------------
        reset = 1'b0;
        tick(); tick();
        check("rst_en", LCD_EN, 1'b0);
        check("rst_rs", LCD_RS, 1'b0);
        check("rst_data", LCD_DATA, 8'h00);
        check("rst_rw", LCD_RW, 1'b0);
        check("rst_on", LCD_ON, 1'b0);
        check("rst_busy", busy, 1'b1);

        // ---------------- 1: init sequence ----------------
        clear_caps();
        reset = 1'b1;
        tick();
        check("on_after_reset", LCD_ON, 1'b1);
        check("busy_in_pwrup", busy, 1'b1);
        wait_idle("init_done", 500);
        check_init();

        // ---------------- 2+3: refresh with mid-refresh text change ----------
        t1 = mk_text("P1:3  LEVEL 5  P2:1");
        text = t1;
        clear_caps();
        pulse_update();
        check("busy_after_strobe", busy, 1'b1);
        wait_caps("t3_mid", 8, 1000);
        text = {32{8'h58}};
        wait_idle("refresh1_done", 2000);
        check("refresh1_total", cap_data.size(), 34);
        check_refresh("r1", t1, 0);

        // ---------------- 4: queued request collapse ----------------
        t2 = mk_text("HELLO WORLD 1234ABCDEFGHIJKLMNOP");
        t3 = mk_text("second refresh  queued snapshot");
        text = t2;
        clear_caps();
        pulse_update();
        busy_low = 0;
        wait_caps("t4_started", 5, 1000);
        pulse_update(); tick();
        pulse_update(); tick();
        pulse_update();
        text = t3;
        wait_caps("t4_second", 68, 3000);
        check("t4_no_busy_gap", busy_low, 0);
        wait_idle("t4_done", 2000);
        repeat (20) tick();
        check("t4_total", cap_data.size(), 68);
        check_refresh("r2a", t2, 0);
        check_refresh("r2b", t3, 34);

        // ---------------- 5: reset during 10th data byte pulse ----------------
        clear_caps();
        pulse_update();
        wait_caps("t5_progress", 10, 1000);
        begin
            int n = 0;
            while (!LCD_EN && n < 100) begin tick(); n++; end
            check("t5_in_pulse", LCD_EN, 1'b1);
        end
        reset = 1'b0;
        tick();
        check("t5_en_drop", LCD_EN, 1'b0);
        check("t5_busy", busy, 1'b1);
        check("t5_on_off", LCD_ON, 1'b0);
        tick();
        clear_caps();
        reset = 1'b1;
        wait_idle("t5_reinit_done", 500);
        check_init();

        // ---------------- 6: non-printable characters ----------------
        t4 = mk_text("filter test  ABCdefgh 0123456789");
        t4[8*5 +: 8]  = 8'h07;
        t4[8*20 +: 8] = 8'h80;
        text = t4;
        clear_caps();
        pulse_update();
        wait_idle("t6_done", 2000);
        check("t6_total", cap_data.size(), 34);
        if (cap_data.size() >= 34) begin
`ifdef LCD_CHAR_FILTER_EN
            check("t6_byte5", cap_data[6], 8'h20);
            check("t6_byte20", cap_data[22], 8'h20);
`else
            check("t6_byte5", cap_data[6], 8'h07);
            check("t6_byte20", cap_data[22], 8'h80);
`endif
        end
        check_refresh("r6", t4, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_controller.md
Name: lcd_controller

Overview:
- Sequences the board's HD44780-compatible 16x2 character LCD: power-up init, then full-screen refreshes from a 32-character text buffer on request.
- Sits between the score/text formatter (supplies the buffer and an update strobe) and the LCD pins.
- Owns all LCD bus timing.
- Reports busy so the upstream block holds off or relies on a single queued request.

Parameters:
- CLK_HZ, 50000000: master clock frequency; documentation only, all timing is in the cycle parameters below.
- POWERUP_CYCLES, 750000: wait after reset before the first command (15 ms).
- EN_PULSE_CYCLES, 16: LCD_EN high time per byte write.
- CMD_WAIT_CYCLES, 2500: post-write wait for normal commands and data (50 us).
- CLEAR_WAIT_CYCLES, 82000: post-write wait after the clear command 0x01 (1.64 ms).

Ports:
- clk, input, 1: master clock; all logic on rising edge.
- reset, input, 1: synchronous, active-low reset.
- text, input, 256: 32 ASCII chars; byte k = text[8k+7:8k]; k=0..15 is line 1 left-to-right, k=16..31 is line 2.
- update, input, 1: one-cycle strobe requesting a refresh of the whole display from text.
- busy, output, 1: high while initialising or refreshing.
- LCD_DATA, output, 8: LCD data bus.
- LCD_RS, output, 1: 0 = command, 1 = data.
- LCD_RW, output, 1: tied 0 (write only).
- LCD_EN, output, 1: LCD enable strobe.
- LCD_ON, output, 1: panel power; 1 once out of reset.

Behaviour:
- Reset (reset=0 at a clock edge):
  - Outputs: LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, LCD_RW=0, LCD_ON=0, busy=1.
  - State goes to PWRUP; pending flag cleared; snapshot buffer cleared to 0x20.
  - Reset mid-write aborts immediately; LCD_EN drops the next cycle.
- LCD_ON goes to 1 the first cycle after reset deasserts.
- States:
  - PWRUP: counts POWERUP_CYCLES, then INIT.
  - INIT: issues the command sequence 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order with RS=0, then IDLE.
  - IDLE: busy=0.
  - ADDR1: writes command 0x80.
  - LINE1: writes 16 data bytes, k=0..15.
  - ADDR2: writes command 0xC0.
  - LINE2: writes 16 data bytes, k=16..31.
  - Return to IDLE, or to ADDR1 if a request is pending.
- Byte write sub-sequence, identical for commands and data:
  - SETUP: 1 cycle. LCD_DATA and LCD_RS driven, LCD_EN=0.
  - PULSE: LCD_EN=1 for exactly EN_PULSE_CYCLES cycles.
  - HOLD: 1 cycle. LCD_EN=0, data and RS unchanged.
  - WAIT: CLEAR_WAIT_CYCLES if the byte was command 0x01, else CMD_WAIT_CYCLES.
  - LCD_DATA and LCD_RS are stable from SETUP through HOLD.
- Per-byte cost: 2 + EN_PULSE_CYCLES + wait cycles.
- A refresh is 34 byte writes: 2 address commands + 32 data bytes.
- Snapshot:
  - text is sampled into an internal 32-byte buffer in the cycle a refresh is accepted.
  - Changes to text during a refresh do not affect that refresh.
- Update handling:
  - update in IDLE: accept next cycle; busy=1 the cycle after the strobe.
  - update while busy (including PWRUP/INIT): set the pending flag; multiple strobes collapse into one.
  - When the current refresh or init completes with pending=1: clear pending, snapshot text, go directly to ADDR1 with no IDLE cycle; busy stays 1.
  - update coincident with completion of the last byte counts as pending.
- busy is registered and deasserts in the same cycle the state enters IDLE.
- Counters:
  - Wait counter sized for the largest parameter.
  - Character index is 5 bits and wraps only on state change, never mid-line.

Optional Feature:
- Macro LCD_CHAR_FILTER_EN.
- Defined: each data byte outside 0x20..0x7E is replaced by 0x20 at snapshot time; commands are unaffected.
- Undefined: data bytes pass through unmodified.

Test Plan:
Simulation uses POWERUP_CYCLES=20, EN_PULSE_CYCLES=2, CMD_WAIT_CYCLES=4, CLEAR_WAIT_CYCLES=10.
1. Release reset, no update:
   - busy=1 until the init sequence completes.
   - Observed LCD_EN falling-edge captures are 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all with RS=0.
   - Gap after 0x01 is ≥10 idle cycles; EN high exactly 2 cycles per byte; then busy=0.
2. In IDLE, text = "P1:3  LEVEL 5  P2:1" padded with spaces, pulse update:
   - Captures are 0x80 (RS=0), 16 line-1 bytes (RS=1), 0xC0 (RS=0), 16 line-2 bytes (RS=1).
   - Total 34 writes; busy returns to 0.
3. Change text to all 'X' (0x58) mid-refresh: all remaining captured bytes still match the original snapshot.
4. Three update pulses during a refresh: exactly one additional refresh follows, with no busy=0 gap between them.
5. Assert reset mid-PULSE of the 10th data byte: LCD_EN=0 next cycle, busy=1, and the full init sequence repeats.
6. With LCD_CHAR_FILTER_EN defined, text byte 5 = 0x07 and byte 20 = 0x80: captured data for those positions is 0x20. Without the macro, 0x07 and 0x80 are captured.
